// File: rtl/ctrl_seq_pkg.sv
// Shared types and decode truth table for the ctrl_seq control sequencer.
// Holds the opcode and FSM state enums, the control-word struct and the per-opcode words.
package ctrl_seq_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_SETC = 4'd1,
        OP_CLRC = 4'd2,
        OP_NOT  = 4'd3,
        OP_INC  = 4'd4,
        OP_DEC  = 4'd5,
        OP_OUT  = 4'd6,
        OP_IN   = 4'd7,
        OP_PUSH = 4'd8,
        OP_POP  = 4'd9,
        OP_LDD  = 4'd10,
        OP_STD  = 4'd11,
        OP_JMP  = 4'd12,
        OP_CALL = 4'd13,
        OP_RET  = 4'd14,
        OP_RTI  = 4'd15
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INT_PC  = 3'd1,
        ST_INT_FLG = 3'd2,
        ST_INT_VEC = 3'd3,
        ST_RTI_FLG = 3'd4,
        ST_RTI_PC  = 3'd5
    } state_e;

    localparam int CW_ALU_W = 3;

    localparam logic [CW_ALU_W-1:0] ALU_NOP  = 3'd0;
    localparam logic [CW_ALU_W-1:0] ALU_SETC = 3'd1;
    localparam logic [CW_ALU_W-1:0] ALU_CLRC = 3'd2;
    localparam logic [CW_ALU_W-1:0] ALU_NOT  = 3'd3;
    localparam logic [CW_ALU_W-1:0] ALU_INC  = 3'd4;
    localparam logic [CW_ALU_W-1:0] ALU_DEC  = 3'd5;
    localparam logic [CW_ALU_W-1:0] ALU_ADD  = 3'd6;

    typedef struct packed {
        logic [CW_ALU_W-1:0] alu_op;
        logic                alu_src;
        logic                reg_write;
        logic                mem_read;
        logic                mem_write;
        logic                mem_to_reg;
        logic                branch;
        logic                out_en;
        logic                in_en;
        logic                push_pop;
        logic                push_pc;
        logic                pop_pc;
        logic                sp_op;
        logic                push_flags;
        logic                pop_flags;
        logic                vector_sel;
    } ctrl_word_t;

    localparam ctrl_word_t CW_NOP  = '0;
    localparam ctrl_word_t CW_SETC = '{alu_op: ALU_SETC, default: 1'b0};
    localparam ctrl_word_t CW_CLRC = '{alu_op: ALU_CLRC, default: 1'b0};
    localparam ctrl_word_t CW_NOT  = '{alu_op: ALU_NOT, reg_write: 1'b1, default: 1'b0};
    localparam ctrl_word_t CW_INC  = '{alu_op: ALU_INC, reg_write: 1'b1, default: 1'b0};
    localparam ctrl_word_t CW_DEC  = '{alu_op: ALU_DEC, reg_write: 1'b1, default: 1'b0};
    localparam ctrl_word_t CW_OUT  = '{alu_op: ALU_NOP, out_en: 1'b1, default: 1'b0};
    localparam ctrl_word_t CW_IN   = '{alu_op: ALU_NOP, in_en: 1'b1, reg_write: 1'b1, default: 1'b0};
    localparam ctrl_word_t CW_PUSH = '{alu_op: ALU_NOP, push_pop: 1'b1, mem_write: 1'b1,
                                       sp_op: 1'b1, default: 1'b0};
    localparam ctrl_word_t CW_POP  = '{alu_op: ALU_NOP, push_pop: 1'b1, mem_read: 1'b1, sp_op: 1'b1,
                                       mem_to_reg: 1'b1, reg_write: 1'b1, default: 1'b0};
    localparam ctrl_word_t CW_LDD  = '{alu_op: ALU_ADD, alu_src: 1'b1, mem_read: 1'b1,
                                       mem_to_reg: 1'b1, reg_write: 1'b1, default: 1'b0};
    localparam ctrl_word_t CW_STD  = '{alu_op: ALU_ADD, alu_src: 1'b1, mem_write: 1'b1, default: 1'b0};
    localparam ctrl_word_t CW_JMP  = '{alu_op: ALU_NOP, branch: 1'b1, default: 1'b0};
    localparam ctrl_word_t CW_CALL = '{alu_op: ALU_NOP, branch: 1'b1, push_pc: 1'b1, push_pop: 1'b1,
                                       mem_write: 1'b1, sp_op: 1'b1, default: 1'b0};
    localparam ctrl_word_t CW_RET  = '{alu_op: ALU_NOP, pop_pc: 1'b1, mem_read: 1'b1, sp_op: 1'b1,
                                       branch: 1'b1, default: 1'b0};

    // Words emitted by the multi-cycle interrupt entry and RTI return sequences.
    localparam ctrl_word_t CW_INT_PC  = '{alu_op: ALU_NOP, push_pc: 1'b1, push_pop: 1'b1,
                                          mem_write: 1'b1, sp_op: 1'b1, default: 1'b0};
    localparam ctrl_word_t CW_INT_FLG = '{alu_op: ALU_NOP, push_flags: 1'b1, push_pop: 1'b1,
                                          mem_write: 1'b1, sp_op: 1'b1, default: 1'b0};
    localparam ctrl_word_t CW_INT_VEC = '{alu_op: ALU_NOP, mem_read: 1'b1, branch: 1'b1,
                                          vector_sel: 1'b1, default: 1'b0};
    localparam ctrl_word_t CW_RTI_FLG = '{alu_op: ALU_NOP, pop_flags: 1'b1, mem_read: 1'b1,
                                          sp_op: 1'b1, default: 1'b0};
    localparam ctrl_word_t CW_RTI_PC  = '{alu_op: ALU_NOP, pop_pc: 1'b1, mem_read: 1'b1,
                                          sp_op: 1'b1, branch: 1'b1, default: 1'b0};

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: maps an opcode onto its control word.
// RTI is only flagged here; its words come from the sequencer states.
module ctrl_decode
    import ctrl_seq_pkg::*;
#(
    parameter int OPCODE_W = 5
) (
    input  logic [OPCODE_W-1:0] opcode,
    output ctrl_word_t          cw,
    output logic                illegal,
    output logic                is_rti
);

    always_comb begin
        cw      = CW_NOP;
        illegal = 1'b0;
        is_rti  = 1'b0;
        if (opcode > OPCODE_W'(4'hF)) begin
            illegal = 1'b1;
        end else begin
            case (opcode_e'(opcode[3:0]))
                OP_NOP:  cw = CW_NOP;
                OP_SETC: cw = CW_SETC;
                OP_CLRC: cw = CW_CLRC;
                OP_NOT:  cw = CW_NOT;
                OP_INC:  cw = CW_INC;
                OP_DEC:  cw = CW_DEC;
                OP_OUT:  cw = CW_OUT;
                OP_IN:   cw = CW_IN;
                OP_PUSH: cw = CW_PUSH;
                OP_POP:  cw = CW_POP;
                OP_LDD:  cw = CW_LDD;
                OP_STD:  cw = CW_STD;
                OP_JMP:  cw = CW_JMP;
                OP_CALL: cw = CW_CALL;
                OP_RET:  cw = CW_RET;
                OP_RTI:  is_rti = 1'b1;
                default: cw = CW_NOP;
            endcase
        end
    end

endmodule

// File: rtl/ctrl_seq.sv
// Control sequencer: registers decoded control words and runs interrupt entry / RTI sequences.
// Define CTRL_SEQ_FLAGS_SAVE_EN to include the flag push/pop states in both sequences.
module ctrl_seq
    import ctrl_seq_pkg::*;
#(
    parameter int OPCODE_W = 5,
    parameter int ALU_OP_W = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                valid_in,
    input  logic                stall,
    input  logic                flush,
    input  logic                int_req,
    output logic                busy,
    output logic                int_ack,
    output logic                illegal_op,
    output logic                valid_out,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                alu_src,
    output logic                reg_write,
    output logic                mem_read,
    output logic                mem_write,
    output logic                mem_to_reg,
    output logic                branch,
    output logic                out_en,
    output logic                in_en,
    output logic                push_pop,
    output logic                push_pc,
    output logic                pop_pc,
    output logic                sp_op,
    output logic                push_flags,
    output logic                pop_flags,
    output logic                vector_sel
);

`ifdef CTRL_SEQ_FLAGS_SAVE_EN
    localparam logic FLAGS_SAVE = 1'b1;
`else
    localparam logic FLAGS_SAVE = 1'b0;
`endif

    state_e     state;
    ctrl_word_t cw_q;
    logic       valid_q;
    logic       ack_q;
    logic       illegal_q;

    ctrl_word_t dec_cw;
    logic       dec_illegal;
    logic       dec_is_rti;
    logic       int_take;
    logic       issue;

    ctrl_decode #(
        .OPCODE_W (OPCODE_W)
    ) u_decode (
        .opcode  (opcode),
        .cw      (dec_cw),
        .illegal (dec_illegal),
        .is_rti  (dec_is_rti)
    );

    // An interrupt wins over the same-cycle opcode; upstream replays that opcode later.
    assign int_take = int_req & (state == ST_IDLE) & ~stall;
    assign issue    = valid_in & ~stall & (state == ST_IDLE) & ~int_take;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            cw_q      <= CW_NOP;
            valid_q   <= 1'b0;
            ack_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else if (!stall) begin
            cw_q      <= CW_NOP;
            valid_q   <= 1'b0;
            ack_q     <= 1'b0;
            illegal_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (int_take) begin
                        state   <= ST_INT_PC;
                        cw_q    <= CW_INT_PC;
                        valid_q <= 1'b1;
                    end else if (issue && !flush) begin
                        valid_q   <= 1'b1;
                        illegal_q <= dec_illegal;
                        if (dec_is_rti) begin
`ifdef CTRL_SEQ_FLAGS_SAVE_EN
                            state <= ST_RTI_FLG;
                            cw_q  <= CW_RTI_FLG;
`else
                            state <= ST_RTI_PC;
                            cw_q  <= CW_RTI_PC;
`endif
                        end else begin
                            cw_q <= dec_cw;
                        end
                    end
                end
                ST_INT_PC: begin
                    valid_q <= 1'b1;
`ifdef CTRL_SEQ_FLAGS_SAVE_EN
                    state   <= ST_INT_FLG;
                    cw_q    <= CW_INT_FLG;
`else
                    state   <= ST_INT_VEC;
                    cw_q    <= CW_INT_VEC;
                    ack_q   <= 1'b1;
`endif
                end
                ST_INT_FLG: begin
                    state   <= ST_INT_VEC;
                    cw_q    <= CW_INT_VEC;
                    valid_q <= 1'b1;
                    ack_q   <= 1'b1;
                end
                ST_RTI_FLG: begin
                    state   <= ST_RTI_PC;
                    cw_q    <= CW_RTI_PC;
                    valid_q <= 1'b1;
                end
                ST_INT_VEC, ST_RTI_PC: state <= ST_IDLE;
                default:               state <= ST_IDLE;
            endcase
        end
    end

    assign busy       = (state != ST_IDLE);
    assign int_ack    = ack_q;
    assign illegal_op = illegal_q;
    assign valid_out  = valid_q;
    assign alu_op     = ALU_OP_W'(cw_q.alu_op);
    assign alu_src    = cw_q.alu_src;
    assign reg_write  = cw_q.reg_write;
    assign mem_read   = cw_q.mem_read;
    assign mem_write  = cw_q.mem_write;
    assign mem_to_reg = cw_q.mem_to_reg;
    assign branch     = cw_q.branch;
    assign out_en     = cw_q.out_en;
    assign in_en      = cw_q.in_en;
    assign push_pop   = cw_q.push_pop;
    assign push_pc    = cw_q.push_pc;
    assign pop_pc     = cw_q.pop_pc;
    assign sp_op      = cw_q.sp_op;
    // Flag save/restore bits only exist in builds with the flag states.
    assign push_flags = cw_q.push_flags & FLAGS_SAVE;
    assign pop_flags  = cw_q.pop_flags & FLAGS_SAVE;
    assign vector_sel = cw_q.vector_sel;

endmodule

// File: tb/tb_ctrl_seq.sv
// Self-checking bench for ctrl_seq: sequence-queue reference model plus directed literal checks.
// Honours CTRL_SEQ_FLAGS_SAVE_EN the same way the design does.
module tb_ctrl_seq;

    // Bit positions of the flattened output vector compared every cycle.
    localparam logic [21:0] M_VEC   = 22'h000001;
    localparam logic [21:0] M_POPF  = 22'h000002;
    localparam logic [21:0] M_PUSHF = 22'h000004;
    localparam logic [21:0] M_SP    = 22'h000008;
    localparam logic [21:0] M_POPPC = 22'h000010;
    localparam logic [21:0] M_PSHPC = 22'h000020;
    localparam logic [21:0] M_PP    = 22'h000040;
    localparam logic [21:0] M_IN    = 22'h000080;
    localparam logic [21:0] M_OUT   = 22'h000100;
    localparam logic [21:0] M_BR    = 22'h000200;
    localparam logic [21:0] M_M2R   = 22'h000400;
    localparam logic [21:0] M_MW    = 22'h000800;
    localparam logic [21:0] M_MR    = 22'h001000;
    localparam logic [21:0] M_RW    = 22'h002000;
    localparam logic [21:0] M_SRC   = 22'h004000;
    localparam logic [21:0] M_VALID = 22'h040000;
    localparam logic [21:0] M_ILL   = 22'h080000;
    localparam logic [21:0] M_ACK   = 22'h100000;
    localparam logic [21:0] M_BUSY  = 22'h200000;

    localparam logic [21:0] W_INT_PC  = M_BUSY | M_VALID | M_PSHPC | M_PP | M_MW | M_SP;
    localparam logic [21:0] W_INT_FLG = M_BUSY | M_VALID | M_PUSHF | M_PP | M_MW | M_SP;
    localparam logic [21:0] W_INT_VEC = M_BUSY | M_VALID | M_ACK | M_MR | M_BR | M_VEC;
    localparam logic [21:0] W_RTI_FLG = M_BUSY | M_VALID | M_POPF | M_MR | M_SP;
    localparam logic [21:0] W_RTI_PC  = M_BUSY | M_VALID | M_POPPC | M_MR | M_SP | M_BR;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] opcode;
    logic       valid_in;
    logic       stall;
    logic       flush;
    logic       int_req;
    logic       busy, int_ack, illegal_op, valid_out;
    logic [2:0] alu_op;
    logic       alu_src, reg_write, mem_read, mem_write, mem_to_reg, branch, out_en, in_en;
    logic       push_pop, push_pc, pop_pc, sp_op, push_flags, pop_flags, vector_sel;
    logic [21:0] dut_vec;

    int checks   = 0;
    int failures = 0;
    int ack_seen = 0;
    logic check_en = 1'b0;

    logic [21:0] exp_q = '0;
    logic [21:0] seq_q[$];

    ctrl_seq #(
        .OPCODE_W (5),
        .ALU_OP_W (3)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .opcode     (opcode),
        .valid_in   (valid_in),
        .stall      (stall),
        .flush      (flush),
        .int_req    (int_req),
        .busy       (busy),
        .int_ack    (int_ack),
        .illegal_op (illegal_op),
        .valid_out  (valid_out),
        .alu_op     (alu_op),
        .alu_src    (alu_src),
        .reg_write  (reg_write),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_to_reg (mem_to_reg),
        .branch     (branch),
        .out_en     (out_en),
        .in_en      (in_en),
        .push_pop   (push_pop),
        .push_pc    (push_pc),
        .pop_pc     (pop_pc),
        .sp_op      (sp_op),
        .push_flags (push_flags),
        .pop_flags  (pop_flags),
        .vector_sel (vector_sel)
    );

    always #5 clk = ~clk;

    assign dut_vec = {busy, int_ack, illegal_op, valid_out, alu_op, alu_src, reg_write, mem_read,
                      mem_write, mem_to_reg, branch, out_en, in_en, push_pop, push_pc, pop_pc,
                      sp_op, push_flags, pop_flags, vector_sel};

    function automatic logic [21:0] alu_field(input int code);
        return 22'(code) << 15;
    endfunction

    // Control bits an ordinary single-cycle instruction must produce.
    function automatic logic [21:0] table_word(input logic [4:0] op);
        case (op)
            5'd1:    return alu_field(1);
            5'd2:    return alu_field(2);
            5'd3:    return alu_field(3) | M_RW;
            5'd4:    return alu_field(4) | M_RW;
            5'd5:    return alu_field(5) | M_RW;
            5'd6:    return M_OUT;
            5'd7:    return M_IN | M_RW;
            5'd8:    return M_PP | M_MW | M_SP;
            5'd9:    return M_PP | M_MR | M_SP | M_M2R | M_RW;
            5'd10:   return alu_field(6) | M_SRC | M_MR | M_M2R | M_RW;
            5'd11:   return alu_field(6) | M_SRC | M_MW;
            5'd12:   return M_BR;
            5'd13:   return M_BR | M_PSHPC | M_PP | M_MW | M_SP;
            5'd14:   return M_POPPC | M_MR | M_SP | M_BR;
            default: return '0;
        endcase
    endfunction

    // Reference model: a busy output means a sequence is in flight and the queue feeds the next word.
    always @(posedge clk or negedge reset_n) begin
        logic [21:0] nxt;
        if (!reset_n) begin
            seq_q.delete();
            exp_q <= '0;
        end else if (!stall) begin
            nxt = '0;
            if ((exp_q & M_BUSY) != 0) begin
                if (seq_q.size() > 0) nxt = seq_q.pop_front();
            end else if (int_req) begin
`ifdef CTRL_SEQ_FLAGS_SAVE_EN
                seq_q.push_back(W_INT_FLG);
`endif
                seq_q.push_back(W_INT_VEC);
                nxt = W_INT_PC;
            end else if (valid_in && !flush) begin
                if (opcode == 5'd15) begin
`ifdef CTRL_SEQ_FLAGS_SAVE_EN
                    seq_q.push_back(W_RTI_PC);
                    nxt = W_RTI_FLG;
`else
                    nxt = W_RTI_PC;
`endif
                end else begin
                    nxt = M_VALID | table_word(opcode) | ((opcode > 5'd15) ? M_ILL : 22'h0);
                end
            end
            exp_q <= nxt;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            checks++;
            if (dut_vec !== exp_q) begin
                failures++;
                $display("[TB] FAIL cycle_compare t=%0t: got %h expected %h", $time, dut_vec, exp_q);
            end
        end
    end

    task automatic applyStimulus(input logic v, input logic [4:0] op, input logic st,
                                 input logic fl, input logic ir);
        @(negedge clk);
        valid_in = v;
        opcode   = op;
        stall    = st;
        flush    = fl;
        int_req  = ir;
        @(posedge clk);
        #1;
        if (int_ack) ack_seen++;
    endtask

    task automatic checkOutput(input string name, input logic [21:0] actual, input logic [21:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        valid_in = 1'b0;
        opcode   = '0;
        stall    = 1'b0;
        flush    = 1'b0;
        int_req  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_state", dut_vec, 22'h000000);
        check_en = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;

        applyStimulus(0, 5'd0, 0, 0, 0);
        checkOutput("post_reset_idle", dut_vec, 22'h000000);

        applyStimulus(1, 5'd4, 0, 0, 0);
        checkOutput("inc_word", dut_vec, 22'h062000);
        applyStimulus(0, 5'd0, 0, 0, 0);
        checkOutput("after_inc", dut_vec, 22'h000000);

        // Interrupt beats a same-cycle INC, which is replayed afterwards.
        applyStimulus(1, 5'd4, 0, 0, 1);
        checkOutput("int_pc", dut_vec, 22'h240868);
        ack_seen = 0;
`ifdef CTRL_SEQ_FLAGS_SAVE_EN
        applyStimulus(0, 5'd0, 0, 0, 0);
        checkOutput("int_flg", dut_vec, 22'h24084C);
`endif
        applyStimulus(0, 5'd0, 0, 0, 0);
        checkOutput("int_vec", dut_vec, 22'h341201);
        applyStimulus(0, 5'd0, 0, 0, 0);
        checkOutput("int_done", dut_vec, 22'h000000);
        checkOutput("int_ack_single", 22'(ack_seen), 22'd1);
        applyStimulus(1, 5'd4, 0, 0, 0);

        // Stall in the middle of interrupt entry holds the word and the FSM.
        ack_seen = 0;
        applyStimulus(0, 5'd0, 0, 0, 1);
`ifdef CTRL_SEQ_FLAGS_SAVE_EN
        applyStimulus(0, 5'd0, 0, 0, 0);
        applyStimulus(0, 5'd0, 1, 0, 0);
        checkOutput("stall_hold_1", dut_vec, W_INT_FLG);
        applyStimulus(0, 5'd0, 1, 0, 0);
        checkOutput("stall_hold_2", dut_vec, W_INT_FLG);
`else
        applyStimulus(0, 5'd0, 1, 0, 0);
        checkOutput("stall_hold_1", dut_vec, W_INT_PC);
        applyStimulus(0, 5'd0, 1, 0, 0);
        checkOutput("stall_hold_2", dut_vec, W_INT_PC);
`endif
        applyStimulus(0, 5'd0, 0, 0, 0);
        checkOutput("stall_then_vec", dut_vec, W_INT_VEC);
        applyStimulus(0, 5'd0, 0, 0, 0);
        checkOutput("stall_ack_once", 22'(ack_seen), 22'd1);

        // RTI return sequence.
        applyStimulus(1, 5'd15, 0, 0, 0);
`ifdef CTRL_SEQ_FLAGS_SAVE_EN
        checkOutput("rti_flg", dut_vec, 22'h24100A);
        applyStimulus(0, 5'd0, 0, 0, 0);
`endif
        checkOutput("rti_pc", dut_vec, 22'h241218);
        applyStimulus(1, 5'd4, 0, 0, 0);
        checkOutput("rti_back_idle", dut_vec, 22'h000000);

        applyStimulus(1, 5'd20, 0, 0, 0);
        checkOutput("illegal_op", dut_vec, 22'h0C0000);
        applyStimulus(0, 5'd0, 0, 0, 0);
        checkOutput("illegal_clear", dut_vec, 22'h000000);

        applyStimulus(1, 5'd15, 0, 1, 0);
        checkOutput("flush_rti", dut_vec, 22'h000000);
        applyStimulus(1, 5'd10, 0, 1, 0);
        applyStimulus(1, 5'd0, 0, 0, 0);
        checkOutput("nop_issue", dut_vec, 22'h040000);

        // Stall while an ordinary word is live, then int_req arriving during an RTI.
        applyStimulus(1, 5'd5, 0, 0, 0);
        applyStimulus(1, 5'd4, 1, 0, 0);
        checkOutput("stall_hold_dec", dut_vec, 22'h06A000);
        applyStimulus(1, 5'd15, 0, 0, 0);
        applyStimulus(0, 5'd0, 0, 0, 1);
        applyStimulus(0, 5'd0, 0, 0, 1);
        applyStimulus(0, 5'd0, 0, 0, 0);
        repeat (3) applyStimulus(0, 5'd0, 0, 0, 0);

        for (int op = 0; op < 32; op += 3) applyStimulus(1, 5'(op), 0, 0, 0);
        applyStimulus(1, 5'd31, 0, 0, 0);
        applyStimulus(0, 5'd0, 0, 0, 0);

        // Asynchronous reset landing in the INT_VEC cycle.
        applyStimulus(0, 5'd0, 0, 0, 1);
`ifdef CTRL_SEQ_FLAGS_SAVE_EN
        applyStimulus(0, 5'd0, 0, 0, 0);
`endif
        applyStimulus(0, 5'd0, 0, 0, 0);
        checkOutput("pre_reset_vec", dut_vec, W_INT_VEC);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("reset_mid_sequence", dut_vec, 22'h000000);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("first_after_release", dut_vec, 22'h000000);
        applyStimulus(1, 5'd6, 0, 0, 0);
        checkOutput("out_after_reset", dut_vec, 22'h040100);
        applyStimulus(0, 5'd0, 0, 0, 0);
        @(negedge clk);
        check_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
